// File: rtl/uc_sram_master_if.sv
// Command and byte-stream handshakes between the loader and uc_sram_master.
// The master modport is the loader side; the slave modport is the SRAM initiator.
interface uc_sram_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [14:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  wr_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [7:0]  rd_data;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
        input  cmd_ready, wr_ready, rd_valid, rd_data
    );
    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
        output cmd_ready, wr_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/uc_sram_master.sv
// Byte-wide initiator for the cartridge CPLD SRAM port: loads the address with
// two strobed writes, then runs uc_write/uc_read + uc_ack cycles with INC strobes.
module uc_sram_master #(
    parameter int SETUP   = 2,
    parameter int STROBE  = 2,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             reset_n,
    uc_sram_master_if.slave  bus,
    output logic             busy,
    output logic             err,
    inout  wire  [7:0]       uc_data,
    output logic             uc_read,
    output logic             uc_write,
    output logic             set_addr_lo,
    output logic             set_addr_hi,
    output logic             strobe_addr,
    input  logic             uc_ack
);
    localparam int PH_MAX = SETUP + STROBE;
    localparam int PH_W   = $clog2(PH_MAX + 1) + 1;
    localparam int TO_W   = $clog2(TIMEOUT + 1) + 1;

    typedef enum logic [3:0] {
        S_IDLE, S_LO, S_HI, S_WAITLOW, S_WR_REQ, S_RD_REQ, S_RELEASE, S_INC, S_DONE
    } state_t;

    typedef struct packed {
        logic        write;
        logic [14:0] addr;
    } cmd_t;

    state_t            state, state_n;
    logic [PH_W-1:0]   phase, phase_n;
    logic [TO_W-1:0]   tcnt, tcnt_n;
    logic [7:0]        cnt, cnt_n;
    cmd_t              cmd, cmd_n;
    logic [7:0]        wbyte, wbyte_n;
    logic              err_n, rdv_q, rdv_n;
    logic [7:0]        rdd_q, rdd_n;
    logic [1:0]        ack_sync;
    logic              ack_s, timed_out, abort, wr_rdy;
    logic              oe_q, oe_n;
    logic [7:0]        dout_q, dout_n;
    logic              read_n, write_n, lo_n, hi_n, strobe_n;

    assign ack_s         = ack_sync[1];
    assign timed_out     = (tcnt == TO_W'(TIMEOUT - 1));
    assign busy          = (state != S_IDLE);
    assign bus.cmd_ready = (state == S_IDLE);
    assign bus.wr_ready  = wr_rdy;
    assign bus.rd_valid  = rdv_q;
    assign bus.rd_data   = rdd_q;
    assign uc_data       = oe_q ? dout_q : 8'hzz;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            phase       <= '0;
            tcnt        <= '0;
            cnt         <= '0;
            cmd         <= '0;
            wbyte       <= '0;
            err         <= 1'b0;
            rdv_q       <= 1'b0;
            rdd_q       <= '0;
            ack_sync    <= '0;
            oe_q        <= 1'b0;
            dout_q      <= '0;
            uc_read     <= 1'b0;
            uc_write    <= 1'b0;
            set_addr_lo <= 1'b0;
            set_addr_hi <= 1'b0;
            strobe_addr <= 1'b0;
        end else begin
            state       <= state_n;
            phase       <= phase_n;
            tcnt        <= tcnt_n;
            cnt         <= cnt_n;
            cmd         <= cmd_n;
            wbyte       <= wbyte_n;
            err         <= err_n;
            rdv_q       <= rdv_n;
            rdd_q       <= rdd_n;
            ack_sync    <= {ack_sync[0], uc_ack};
            oe_q        <= oe_n;
            dout_q      <= dout_n;
            uc_read     <= read_n;
            uc_write    <= write_n;
            set_addr_lo <= lo_n;
            set_addr_hi <= hi_n;
            strobe_addr <= strobe_n;
        end
    end

    always_comb begin
        state_n = state;
        phase_n = phase;
        tcnt_n  = tcnt + 1'b1;
        cnt_n   = cnt;
        cmd_n   = cmd;
        wbyte_n = wbyte;
        err_n   = err;
        rdv_n   = rdv_q;
        rdd_n   = rdd_q;
        wr_rdy  = 1'b0;
        abort   = 1'b0;
        if (rdv_q && bus.rd_ready) rdv_n = 1'b0;
        case (state)
            S_IDLE: if (bus.cmd_valid) begin
                cmd_n.write = bus.cmd_write;
                cmd_n.addr  = bus.cmd_addr;
                cnt_n       = bus.cmd_len;
                err_n       = 1'b0;
                phase_n     = '0;
                state_n     = S_LO;
            end
            S_LO, S_HI, S_INC: begin
                phase_n = phase + 1'b1;
                if (phase == PH_W'(PH_MAX)) begin
                    phase_n = '0;
                    state_n = (state == S_LO) ? S_HI : S_WAITLOW;
                end
            end
            // A stale ack from a previous (possibly reset) transfer must clear first.
            S_WAITLOW: if (!ack_s) begin
                if (cmd.write) begin
                    wr_rdy = 1'b1;
                    if (bus.wr_valid) begin
                        wbyte_n = bus.wr_data;
                        tcnt_n  = '0;
                        state_n = S_WR_REQ;
                    end
                end else if (!rdv_q) begin
                    tcnt_n  = '0;
                    state_n = S_RD_REQ;
                end
            end
            S_WR_REQ: if (ack_s) begin
                tcnt_n  = '0;
                state_n = S_RELEASE;
            end else if (timed_out) abort = 1'b1;
            S_RD_REQ: if (ack_s) begin
                rdd_n   = uc_data;
                rdv_n   = 1'b1;
                tcnt_n  = '0;
                state_n = S_RELEASE;
            end else if (timed_out) abort = 1'b1;
            S_RELEASE: if (!ack_s) begin
                if (cnt == 8'd0) state_n = S_DONE;
                else begin
                    cnt_n   = cnt - 1'b1;
                    phase_n = '0;
                    state_n = S_INC;
                end
            end else if (timed_out) abort = 1'b1;
            S_DONE: if (!rdv_q) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        if (abort) begin
            err_n   = 1'b1;
            rdv_n   = 1'b0;
            state_n = S_IDLE;
        end

        // Pins are registered from the next state so they change with the state.
        lo_n     = (state_n == S_LO);
        hi_n     = (state_n == S_HI);
        read_n   = (state_n == S_RD_REQ);
        write_n  = (state_n == S_WR_REQ);
        oe_n     = (state_n == S_LO) || (state_n == S_HI) || (state_n == S_INC) ||
                   (state_n == S_WR_REQ);
        strobe_n = ((state_n == S_LO) || (state_n == S_HI) || (state_n == S_INC)) &&
                   (phase_n >= PH_W'(SETUP)) && (phase_n < PH_W'(PH_MAX));
        dout_n   = 8'h00;
        case (state_n)
            S_LO:     dout_n = cmd_n.addr[7:0];
            S_HI:     dout_n = {1'b0, cmd_n.addr[14:8]};
            S_WR_REQ: dout_n = wbyte_n;
            default:  dout_n = 8'h00;
        endcase
    end
endmodule
